sample_format_conv: RTL and testbench
=====================================

// Module: sample_format_conv
// PURPOSE
// - Parametrised multi-channel audio sample format converter between codec data path and DSP core.
// - Converts interleaved samples among several formats (offset-binary, sign-magnitude, two's complement),
//   with optional polarity inversion and rounded attenuation.
// - Uses a 2-stage elastic valid/ready pipeline and tags each output with its channel index.
// PARAMETERS
// - DATA_W    16  sample width in bits (>=4)
// - CHANNELS  2   interleaved channels per frame (>=1); CH_W = max(1,$clog2(CHANNELS))
// - SHIFT_W   4   width of cfg_shift; legal shift 0..DATA_W-1, larger values clamp to DATA_W-1
// PORTS
// - clk        in   1        system clock; all logic on posedge
// - rst        in   1        synchronous, active-high reset
// - cfg_mode   in   2        0 pass, 1 flip MSB (offset<->two's), 2 sign-mag->two's, 3 two's negate
// - cfg_shift  in   SHIFT_W  arithmetic right-shift (attenuation) amount
// - s_valid    in   1        input sample valid
// - s_ready    out  1        input accepted when s_valid&&s_ready
// - s_data     in   DATA_W   input sample
// - s_first    in   1        marks channel 0 of a frame (resync hint)
// - m_valid    out  1        output sample valid
// - m_ready    in   1        downstream ready
// - m_data     out  DATA_W   converted signed sample
// - m_chan     out  CH_W     channel index of m_data
// - m_first    out  1        high when m_chan==0
// - sync_err   out  1        sticky: s_first seen while channel counter !=0
// BEHAVIOUR
// - Reset: s_ready=1 after reset; m_valid=0, m_data=0, m_chan=0, m_first=0, sync_err=0;
//   channel counter=0, active mode=0, active shift=0; both pipe stages empty.
// - Handshake: a transfer occurs only on valid&&ready. m_data/m_chan/m_first hold stable while m_valid&&!m_ready.
// - s_ready = !v1 || !v2 || m_ready. Stage 1 loads on input accept; stage 2 loads from stage 1 when empty or draining.
// - Latency: 2 cycles accept->m_valid with m_ready=1. Throughput: 1 sample/cycle.
// - Channel counter: increments on each accept; wraps CHANNELS-1 -> 0.
//   If s_first is set on an accept, the sample is channel 0 and the counter becomes 1 (or 0 if CHANNELS==1).
//   If the counter was !=0, sync_err is set, and stays set until rst.
// - Config: cfg_mode/cfg_shift are sampled into active regs only on accept of a channel-0 sample,
//   so every sample in a frame uses one config. Each config travels with its sample through the pipe.
// - Stage 1 (format), x=s_data:
//   - mode 0: x.
//   - mode 1: {~x[MSB],x[MSB-1:0]}.
//   - mode 2: MSB=0 -> x; MSB=1 -> -(x[MSB-1:0]). Negative zero maps to 0.
//   - mode 3: -x, saturating; most-negative maps to most-positive.
// - Stage 2 (attenuate): s=min(shift,DATA_W-1).
//   - s=0: y=x. s>0: y=(x + 2^(s-1)) >>> s, computed in DATA_W+1 bits.
//   - Result then saturates to DATA_W signed. Rounding is half-up toward +inf.
// - rst mid-stream: in-flight samples are dropped, counter returns to 0, and no partial output is emitted.
// - Simultaneous stage-2 output and stage-1 refill in the same cycle is legal and loses no data.
// STRUCTURE
// - Package audio_fmt_pkg: mode enum (FMT_PASS, FMT_FLIPMSB, FMT_SIGNMAG, FMT_NEG),
//   sat/round helper functions, CH_W derivation function.
// - Sub-module elastic_stage #(W): one valid/ready register slice, instantiated twice.
//   Format/attenuate logic is combinational between the two instances.
// TESTING
// - DATA_W=16, mode 1, shift 0: in 16'h0000, 16'h8000, 16'hFFFF -> out 16'h8000, 16'h0000, 16'h7FFF.
//   Each arrives exactly 2 cycles after accept.
// - Mode 3: in 16'h8000 -> 16'h7FFF (sat); 16'h0001 -> 16'hFFFF.
//   Mode 2: in 16'h8005 -> 16'hFFFB; 16'h8000 -> 16'h0000.
// - Mode 0, shift 2: in 16'h0006 -> 16'h0002; 16'hFFFA (-6) -> 16'hFFFF (-1); 16'h7FFF -> 16'h2000.
// - CHANNELS=2, 6 samples, s_first on 1st only -> m_chan 0,1,0,1,0,1 and m_first 1,0,1,0,1,0.
//   Then s_first on a channel-1 slot -> sync_err=1, that sample tagged channel 0.
// - Backpressure: m_ready random 50%, 1000 samples -> no loss or duplication, order preserved.
//   Outputs stay stable while stalled, and s_ready drops only when both stages are full and m_ready=0.
// - Change cfg_mode mid-frame -> new mode applies from the next channel-0 sample.
//   Assert rst with 2 samples in flight -> m_valid=0 next cycle, counter=0.

Source files
------------

// File: rtl/sample_format_conv_pkg.sv
// Shared types and arithmetic helpers for the sample format converter.
package audio_fmt_pkg;

  typedef enum logic [1:0] {
    FMT_PASS    = 2'd0,
    FMT_FLIPMSB = 2'd1,
    FMT_SIGNMAG = 2'd2,
    FMT_NEG     = 2'd3
  } fmt_mode_e;

  // Wide signed scratch type; arithmetic is done here and narrowed at the end.
  localparam int WIDE_W = 64;
  typedef logic signed [WIDE_W-1:0] wide_t;

  // Channel index width, never below one bit.
  function automatic int ch_w(input int channels);
    return (channels <= 1) ? 1 : $clog2(channels);
  endfunction

  // Arithmetic right shift with half-up rounding (ties go toward +inf).
  function automatic wide_t round_shr(input wide_t x, input int s);
    if (s <= 0) return x;
    return (x + (wide_t'(1) <<< (s - 1))) >>> s;
  endfunction

  // Clamp to the range of a w-bit signed value.
  function automatic wide_t sat_w(input wide_t x, input int w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/sample_format_conv_if.sv
// Stream and config bundle between codec path and DSP core.
interface sample_format_conv_if #(
  parameter int DATA_W   = 16,
  parameter int CHANNELS = 2,
  parameter int SHIFT_W  = 4
);
  localparam int CH_W = audio_fmt_pkg::ch_w(CHANNELS);

  logic [1:0]         cfg_mode;
  logic [SHIFT_W-1:0] cfg_shift;
  logic               s_valid;
  logic               s_ready;
  logic [DATA_W-1:0]  s_data;
  logic               s_first;
  logic               m_valid;
  logic               m_ready;
  logic [DATA_W-1:0]  m_data;
  logic [CH_W-1:0]    m_chan;
  logic               m_first;
  logic               sync_err;

  modport master (
    output cfg_mode, cfg_shift, s_valid, s_data, s_first, m_ready,
    input  s_ready, m_valid, m_data, m_chan, m_first, sync_err
  );

  modport slave (
    input  cfg_mode, cfg_shift, s_valid, s_data, s_first, m_ready,
    output s_ready, m_valid, m_data, m_chan, m_first, sync_err
  );
endinterface

// File: rtl/sample_format_conv_elastic_stage.sv
// One valid/ready register slice: accepts when empty or when draining.
module elastic_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Load on accept, otherwise empty on drain; data holds while stalled.
  always_comb begin
    in_ready_o = !valid_q || out_ready_i;
    valid_d    = valid_q;
    data_d     = data_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Slice register.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
endmodule

// File: rtl/sample_format_conv.sv
// Multi-channel sample format converter: tag/config at input, format and
// attenuate between two elastic slices.
module sample_format_conv
  import audio_fmt_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int CHANNELS = 2,
  parameter int SHIFT_W  = 4
) (
  input logic                clk,
  input logic                rst,
  sample_format_conv_if.slave bus
);
  localparam int CH_W = ch_w(CHANNELS);
  // Stage-1 payload: raw sample plus the config and channel it travels with.
  localparam int P1_W = DATA_W + 2 + SHIFT_W + CH_W;
  // Stage-2 payload: converted sample, channel, first flag.
  localparam int P2_W = DATA_W + CH_W + 1;

  logic [CH_W-1:0]    chan_cnt_q, chan_cnt_d;
  fmt_mode_e          mode_q, mode_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               sync_err_q, sync_err_d;

  logic               accept;
  logic [CH_W-1:0]    in_chan;
  fmt_mode_e          use_mode;
  logic [SHIFT_W-1:0] use_shift;

  logic               s1_in_ready, s1_valid, s2_in_ready, s2_valid;
  logic [P1_W-1:0]    p1_in, p1_out;
  logic [P2_W-1:0]    p2_in, p2_out;

  logic [DATA_W-1:0]  s1_data;
  fmt_mode_e          s1_mode;
  logic [SHIFT_W-1:0] s1_shift;
  logic [CH_W-1:0]    s1_chan;

  wide_t              xs, mag, f_w;
  int                 s_eff;
  logic [DATA_W-1:0]  att;

  // Channel tagging, per-frame config capture and resync error detection.
  always_comb begin
    accept  = bus.s_valid && s1_in_ready;
    in_chan = bus.s_first ? '0 : chan_cnt_q;
    if (in_chan == '0) begin
      use_mode  = fmt_mode_e'(bus.cfg_mode);
      use_shift = bus.cfg_shift;
    end else begin
      use_mode  = mode_q;
      use_shift = shift_q;
    end
    chan_cnt_d = chan_cnt_q;
    mode_d     = mode_q;
    shift_d    = shift_q;
    sync_err_d = sync_err_q;
    if (accept) begin
      if (in_chan == '0) begin
        mode_d  = use_mode;
        shift_d = use_shift;
      end
      if (bus.s_first && (chan_cnt_q != '0)) sync_err_d = 1'b1;
      // Counting from the tagged channel also covers the s_first restart.
      if (int'(in_chan) == CHANNELS - 1) chan_cnt_d = '0;
      else                               chan_cnt_d = in_chan + CH_W'(1);
    end
  end

  // Counter, active config and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      chan_cnt_q <= '0;
      mode_q     <= FMT_PASS;
      shift_q    <= '0;
      sync_err_q <= 1'b0;
    end else begin
      chan_cnt_q <= chan_cnt_d;
      mode_q     <= mode_d;
      shift_q    <= shift_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign p1_in = {bus.s_data, 2'(use_mode), use_shift, in_chan};

  elastic_stage #(.W(P1_W)) u_s1 (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (bus.s_valid),
    .in_ready_o (s1_in_ready),
    .in_data_i  (p1_in),
    .out_valid_o(s1_valid),
    .out_ready_i(s2_in_ready),
    .out_data_o (p1_out)
  );

  assign s1_chan  = p1_out[CH_W-1:0];
  assign s1_shift = p1_out[CH_W +: SHIFT_W];
  assign s1_mode  = fmt_mode_e'(p1_out[CH_W+SHIFT_W +: 2]);
  assign s1_data  = p1_out[CH_W+SHIFT_W+2 +: DATA_W];

  // Format conversion then rounded, saturated attenuation.
  always_comb begin
    xs  = wide_t'(signed'(s1_data));
    mag = wide_t'({1'b0, s1_data[DATA_W-2:0]});
    case (s1_mode)
      FMT_PASS:    f_w = xs;
      FMT_FLIPMSB: f_w = wide_t'(signed'({~s1_data[DATA_W-1], s1_data[DATA_W-2:0]}));
      FMT_SIGNMAG: f_w = s1_data[DATA_W-1] ? -mag : xs;
      FMT_NEG:     f_w = sat_w(-xs, DATA_W);
      default:     f_w = xs;
    endcase
    s_eff = (int'(s1_shift) > DATA_W - 1) ? DATA_W - 1 : int'(s1_shift);
    att   = DATA_W'(sat_w(round_shr(f_w, s_eff), DATA_W));
  end

  assign p2_in = {att, s1_chan, (s1_chan == '0)};

  elastic_stage #(.W(P2_W)) u_s2 (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (s1_valid),
    .in_ready_o (s2_in_ready),
    .in_data_i  (p2_in),
    .out_valid_o(s2_valid),
    .out_ready_i(bus.m_ready),
    .out_data_o (p2_out)
  );

  assign bus.s_ready  = s1_in_ready;
  assign bus.m_valid  = s2_valid;
  assign bus.m_first  = p2_out[0];
  assign bus.m_chan   = p2_out[1 +: CH_W];
  assign bus.m_data   = p2_out[1+CH_W +: DATA_W];
  assign bus.sync_err = sync_err_q;
endmodule

// File: tb/tb_sample_format_conv.sv
// Bench for sample_format_conv: behavioural scoreboard plus directed vectors.
module tb_sample_format_conv;
  logic clk;
  logic rst;
  sample_format_conv_if #(.DATA_W(16), .CHANNELS(2), .SHIFT_W(4)) bus();

  sample_format_conv #(.DATA_W(16), .CHANNELS(2), .SHIFT_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [15:0] d; int ch; } exp_t;
  exp_t        q[$];
  logic [15:0] out_log[$];
  int          chan_log[$];
  int n_cmp = 0, n_bad = 0, n_in = 0, n_out = 0;
  int m_cnt = 0, m_mode = 0, m_shift = 0;
  logic m_serr = 1'b0;
  bit just_rst = 0, prev_stall = 0, bp_rand = 0, hold_ready = 1;
  logic [15:0] prev_d;
  logic [0:0]  prev_c;
  logic        prev_f;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference conversion from the plain arithmetic definition.
  function automatic logic [15:0] model_conv(input int mode, input int shift, input logic [15:0] x);
    int v, s, d, num, qq;
    case (mode)
      0: v = int'($signed(x));
      1: v = int'($signed(x ^ 16'h8000));
      2: v = x[15] ? -int'(x[14:0]) : int'(x);
      default: begin v = -int'($signed(x)); if (v > 32767) v = 32767; end
    endcase
    s = (shift > 15) ? 15 : shift;
    if (s > 0) begin
      d = 1 << s;
      num = v + d / 2;
      qq = num / d;
      if ((num % d != 0) && (num < 0)) qq = qq - 1;
      v = qq;
    end
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return 16'(v);
  endfunction

  // Scoreboard and per-cycle protocol checks.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_cnt = 0; m_mode = 0; m_shift = 0; m_serr = 1'b0;
      just_rst = 1; prev_stall = 0;
    end else begin
      if (just_rst) begin
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_m_chan", bus.m_chan, 0);
        chk("rst_m_first", bus.m_first, 0);
        just_rst = 0;
      end
      chk("sync_err", bus.sync_err, m_serr);
      chk("s_ready", bus.s_ready, (q.size() < 2) || bus.m_ready);
      if (q.size() >= 2) chk("m_valid_full", bus.m_valid, 1);
      if (prev_stall) begin
        chk("hold_data", bus.m_data, prev_d);
        chk("hold_chan", bus.m_chan, prev_c);
        chk("hold_first", bus.m_first, prev_f);
      end
      if (bus.m_valid) begin
        chk("out_has_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          chk("m_data", bus.m_data, q[0].d);
          chk("m_chan", bus.m_chan, q[0].ch);
          chk("m_first", bus.m_first, q[0].ch == 0);
          if (bus.m_ready) begin
            out_log.push_back(bus.m_data);
            chan_log.push_back(int'(bus.m_chan));
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_d = bus.m_data; prev_c = bus.m_chan; prev_f = bus.m_first;
      if (bus.s_valid && bus.s_ready) begin
        exp_t e;
        int ch;
        ch = bus.s_first ? 0 : m_cnt;
        if (bus.s_first && m_cnt != 0) m_serr = 1'b1;
        if (ch == 0) begin m_mode = int'(bus.cfg_mode); m_shift = int'(bus.cfg_shift); end
        m_cnt = (ch + 1) % 2;
        e.d = model_conv(m_mode, m_shift, bus.s_data);
        e.ch = ch;
        q.push_back(e);
        n_in++;
      end
    end
  end

  // Downstream ready driver.
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.m_ready = bp_rand ? 1'($urandom_range(0, 1)) : 1'(hold_ready);
    end
  end

  task automatic send(input logic [15:0] d, input logic f);
    bit ok;
    ok = 0;
    bus.s_valid = 1'b1; bus.s_data = d; bus.s_first = f;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.s_ready) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    bus.s_valid = 1'b0; bus.s_first = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.m_valid) begin ok = 1; break; end
    end
    if (!ok) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [3:0] s);
    bus.cfg_mode = m; bus.cfg_shift = s;
  endtask

  // Frame of two samples under one config, checked against literals.
  task automatic pair(input string nm, input logic [1:0] m, input logic [3:0] s,
                      input logic [15:0] a, input logic [15:0] ea,
                      input logic [15:0] b, input logic [15:0] eb);
    int base;
    chk({nm, "_pin_a"}, model_conv(int'(m), int'(s), a), ea);
    chk({nm, "_pin_b"}, model_conv(int'(m), int'(s), b), eb);
    base = out_log.size();
    set_cfg(m, s);
    send(a, 1'b0);
    send(b, 1'b0);
    drain();
    chk({nm, "_a"}, out_log[base], ea);
    chk({nm, "_b"}, out_log[base + 1], eb);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_first = 1'b0;
    set_cfg(2'd0, 4'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Latency: accept at edge P, output visible after edge P+1.
    set_cfg(2'd1, 4'd0);
    base = out_log.size();
    bus.s_valid = 1'b1; bus.s_data = 16'h0000;
    @(posedge clk); #1 bus.s_valid = 1'b0;
    @(negedge clk); chk("lat_cycle1", bus.m_valid, 0);
    @(negedge clk); chk("lat_cycle2", bus.m_valid, 1);
    chk("lat_data", bus.m_data, 16'h8000);
    @(posedge clk); #1;
    send(16'h8000, 1'b0);
    send(16'hFFFF, 1'b0);
    send(16'h0000, 1'b0);
    drain();
    chk("flip_8000", out_log[base + 1], 16'h0000);
    chk("flip_FFFF", out_log[base + 2], 16'h7FFF);

    pair("neg",     2'd3, 4'd0,  16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF);
    pair("signmag", 2'd2, 4'd0,  16'h8005, 16'hFFFB, 16'h8000, 16'h0000);
    pair("sh2a",    2'd0, 4'd2,  16'h0006, 16'h0002, 16'hFFFA, 16'hFFFF);
    pair("sh2b",    2'd0, 4'd2,  16'h7FFF, 16'h2000, 16'h0000, 16'h0000);
    pair("sh15",    2'd0, 4'd15, 16'h7FFF, 16'h0001, 16'h8000, 16'hFFFF);

    // Channel tagging with s_first on the first sample only.
    set_cfg(2'd0, 4'd0);
    base = chan_log.size();
    for (int i = 0; i < 6; i++) send(16'h0100 + 16'(i), i == 0);
    drain();
    for (int i = 0; i < 6; i++) chk("chan_seq", chan_log[base + i], i % 2);

    // s_first on a channel-1 slot: sticky error, retagged as channel 0.
    send(16'h0200, 1'b0);
    send(16'h0201, 1'b1);
    drain();
    chk("sync_err_set", bus.sync_err, 1);
    chk("resync_chan", chan_log[chan_log.size() - 1], 0);

    // Config change mid-frame takes effect at next channel 0.
    base = out_log.size();
    set_cfg(2'd3, 4'd0);
    send(16'h0001, 1'b0);
    send(16'h0001, 1'b0);
    send(16'h0000, 1'b0);
    drain();
    chk("midframe_old", out_log[base], 16'h0001);
    chk("midframe_new", out_log[base + 1], 16'hFFFF);

    // Random backpressure, gaps and configs.
    bp_rand = 1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      set_cfg(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      send(16'($urandom), 1'b0);
    end
    bp_rand = 0; hold_ready = 1;
    drain();
    chk("in_out_count", n_out, n_in);

    // Reset with two samples in flight.
    hold_ready = 0;
    @(posedge clk); #1;
    set_cfg(2'd0, 4'd0);
    send(16'h0011, 1'b0);
    send(16'h0022, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    hold_ready = 1;
    base = out_log.size();
    send(16'h0003, 1'b0);
    drain();
    chk("post_rst_count", out_log.size(), base + 1);
    chk("post_rst_data", out_log[out_log.size() - 1], 16'h0003);
    chk("post_rst_chan", chan_log[chan_log.size() - 1], 0);
    chk("post_rst_serr", bus.sync_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
